// File: rtl/sram_port_arbiter_pkg.sv
// rtl/sram_port_arbiter_pkg.sv - shared types and constants for the SRAM port arbiter
// Package sram_arb_pkg: FSM state encoding, default region offsets, timeout error word.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2,
        ST_GAP    = 2'd3
    } arb_state_t;

    localparam logic [31:0] IMEM_OFS_DEF = 32'h0000_0001;
    localparam logic [31:0] DMEM_OFS_DEF = 32'h0040_0001;
    localparam logic [31:0] ERR_WORD     = 32'hDEAD_BEEF;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// rtl/sram_port_arbiter_if.sv - bus bundle between CPU requesters, arbiter and SRAM controller
// Signals: fetch port (if_*), data port (d_*), controller port (sram_*), arb_err.
// Modports: slave = arbiter view, master = CPU/controller view.
interface sram_port_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;

    logic              sram_en;
    logic              sram_wr;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;
    logic              sram_read_done;
    logic              sram_write_done;

    logic              arb_err;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata,
        input  sram_rdata, sram_read_done, sram_write_done,
        output if_rdata, if_done, d_rdata, d_done,
        output sram_en, sram_wr, sram_addr, sram_wdata, arb_err
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata,
        output sram_rdata, sram_read_done, sram_write_done,
        input  if_rdata, if_done, d_rdata, d_done,
        input  sram_en, sram_wr, sram_addr, sram_wdata, arb_err
    );

endinterface

// File: rtl/sram_port_arbiter_addr_map.sv
// rtl/sram_port_arbiter_addr_map.sv - word address to controller halfword address mapping
// Ports: addr (word address in), mapped ((addr<<1)+OFS, wraps at ADDR_W bits).
module sram_addr_map #(
    parameter int              ADDR_W = 32,
    parameter logic [ADDR_W-1:0] OFS  = '0
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] mapped
);

    assign mapped = (addr << 1) + OFS;

endmodule

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - two-port (fetch/data) arbiter in front of a single SRAM controller
// Ports: clk, rst (async active-low), bus (sram_port_arbiter_if.slave: fetch, data,
// controller and arb_err signals). Optional macro ARB_TIMEOUT_EN adds a BUSY watchdog.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] IMEM_OFS = IMEM_OFS_DEF,
    parameter logic [ADDR_W-1:0] DMEM_OFS = DMEM_OFS_DEF
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int                TMO_CYC  = 4096
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    sram_port_arbiter_if.slave   bus
);

    arb_state_t        state;
    logic              sram_en_q;
    logic              sram_wr_q;
    logic [ADDR_W-1:0] sram_addr_q;
    logic [DATA_W-1:0] sram_wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              if_done_q;
    logic              d_done_q;
    logic              arb_err_q;

    logic [ADDR_W-1:0] if_mapped;
    logic [ADDR_W-1:0] d_mapped;
    logic              complete;

    sram_addr_map #(.ADDR_W(ADDR_W), .OFS(IMEM_OFS)) u_if_map (
        .addr   (bus.if_addr),
        .mapped (if_mapped)
    );

    sram_addr_map #(.ADDR_W(DATA_W == DATA_W ? ADDR_W : ADDR_W), .OFS(DMEM_OFS)) u_d_map (
        .addr   (bus.d_addr),
        .mapped (d_mapped)
    );

    // Only the done pulse matching the latched direction ends a transaction.
    assign complete = sram_wr_q ? bus.sram_write_done : bus.sram_read_done;

`ifdef ARB_TIMEOUT_EN
    logic [15:0] tmo_cnt;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            sram_en_q    <= 1'b0;
            sram_wr_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            if_done_q    <= 1'b0;
            d_done_q     <= 1'b0;
            arb_err_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            tmo_cnt      <= '0;
`endif
        end else begin
            if_done_q <= 1'b0;
            d_done_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Data wins: the stalled instruction is the one waiting on it.
                    if (bus.d_req) begin
                        state        <= ST_BUSY_D;
                        sram_en_q    <= 1'b1;
                        sram_wr_q    <= bus.d_we;
                        sram_addr_q  <= d_mapped;
                        sram_wdata_q <= bus.d_wdata;
`ifdef ARB_TIMEOUT_EN
                        tmo_cnt      <= '0;
`endif
                    end else if (bus.if_req) begin
                        state        <= ST_BUSY_I;
                        sram_en_q    <= 1'b1;
                        sram_wr_q    <= 1'b0;
                        sram_addr_q  <= if_mapped;
                        sram_wdata_q <= bus.d_wdata;
`ifdef ARB_TIMEOUT_EN
                        tmo_cnt      <= '0;
`endif
                    end
                end
                ST_BUSY_I, ST_BUSY_D: begin
                    if (complete) begin
                        state     <= ST_GAP;
                        sram_en_q <= 1'b0;
                        if (state == ST_BUSY_I) begin
                            if_done_q  <= 1'b1;
                            if_rdata_q <= bus.sram_rdata;
                        end else begin
                            d_done_q <= 1'b1;
                            if (!sram_wr_q) begin
                                d_rdata_q <= bus.sram_rdata;
                            end
                        end
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (tmo_cnt == 16'(TMO_CYC - 1)) begin
                        state     <= ST_GAP;
                        sram_en_q <= 1'b0;
                        arb_err_q <= 1'b1;
                        if (state == ST_BUSY_I) begin
                            if_done_q  <= 1'b1;
                            if_rdata_q <= DATA_W'(ERR_WORD);
                        end else begin
                            d_done_q  <= 1'b1;
                            d_rdata_q <= DATA_W'(ERR_WORD);
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
`endif
                end
                // GAP plus the following IDLE cycle keep sram_en low for two cycles
                // so the controller's edge detectors re-arm.
                ST_GAP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.sram_en    = sram_en_q;
    assign bus.sram_wr    = sram_wr_q;
    assign bus.sram_addr  = sram_addr_q;
    assign bus.sram_wdata = sram_wdata_q;
    assign bus.if_rdata   = if_rdata_q;
    assign bus.d_rdata    = d_rdata_q;
    assign bus.if_done    = if_done_q;
    assign bus.d_done     = d_done_q;
    assign bus.arb_err    = arb_err_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - directed self-checking bench for sram_port_arbiter
module tb_sram_port_arbiter;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    sram_port_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    sram_port_arbiter #(
        .DATA_W (32),
        .ADDR_W (32)
`ifdef ARB_TIMEOUT_EN
        ,
        .TMO_CYC(8)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_en"},    32'(bus.sram_en), 32'd0);
        check_eq({tag, "_wr"},    32'(bus.sram_wr), 32'd0);
        check_eq({tag, "_addr"},  bus.sram_addr, 32'd0);
        check_eq({tag, "_wdata"}, bus.sram_wdata, 32'd0);
        check_eq({tag, "_ifrd"},  bus.if_rdata, 32'd0);
        check_eq({tag, "_drd"},   bus.d_rdata, 32'd0);
        check_eq({tag, "_ifdn"},  32'(bus.if_done), 32'd0);
        check_eq({tag, "_ddn"},   32'(bus.d_done), 32'd0);
        check_eq({tag, "_err"},   32'(bus.arb_err), 32'd0);
    endtask

    initial begin
        int seen;
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.sram_rdata = '0; bus.sram_read_done = 1'b0; bus.sram_write_done = 1'b0;

        repeat (2) tick();
        check_idle_outputs("rst");
        rst = 1'b1;
        tick();

        // Fetch read, controller answers 5 cycles after sram_en
        bus.if_addr = 32'h10; bus.if_req = 1'b1;
        tick();
        check_eq("f_en",   32'(bus.sram_en), 32'd1);
        check_eq("f_addr", bus.sram_addr, 32'h21);
        check_eq("f_wr",   32'(bus.sram_wr), 32'd0);
        repeat (4) tick();
        check_eq("f_nodone", 32'(bus.if_done), 32'd0);
        bus.sram_rdata = 32'h8C080004; bus.sram_read_done = 1'b1;
        tick();
        bus.sram_read_done = 1'b0; bus.if_req = 1'b0;
        check_eq("f_done",  32'(bus.if_done), 32'd1);
        check_eq("f_rdata", bus.if_rdata, 32'h8C080004);
        check_eq("f_en0",   32'(bus.sram_en), 32'd0);
        tick();
        check_eq("f_pulse", 32'(bus.if_done), 32'd0);

        // Store; a stray read_done mid-BUSY must be ignored
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h3; bus.d_wdata = 32'h55AA;
        tick();
        check_eq("s_en",    32'(bus.sram_en), 32'd1);
        check_eq("s_addr",  bus.sram_addr, 32'h0040_0007);
        check_eq("s_wr",    32'(bus.sram_wr), 32'd1);
        check_eq("s_wdata", bus.sram_wdata, 32'h55AA);
        bus.d_wdata = 32'h1111; bus.d_addr = 32'h9;
        bus.sram_read_done = 1'b1;
        tick();
        bus.sram_read_done = 1'b0;
        check_eq("s_ignrd", 32'(bus.d_done), 32'd0);
        check_eq("s_hold",  32'(bus.sram_en), 32'd1);
        check_eq("s_addrh", bus.sram_addr, 32'h0040_0007);
        tick();
        bus.sram_write_done = 1'b1;
        tick();
        bus.sram_write_done = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0;
        check_eq("s_done", 32'(bus.d_done), 32'd1);
        check_eq("s_en0",  32'(bus.sram_en), 32'd0);
        tick();
        check_eq("s_pulse", 32'(bus.d_done), 32'd0);

        // Contention: data load first, then fetch after a 2-cycle en-low gap
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0;
        bus.if_req = 1'b1; bus.if_addr = 32'h10;
        tick();
        check_eq("c_daddr", bus.sram_addr, 32'h0040_0001);
        check_eq("c_dwr",   32'(bus.sram_wr), 32'd0);
        bus.sram_rdata = 32'h1234_5678; bus.sram_read_done = 1'b1;
        tick();
        bus.sram_read_done = 1'b0; bus.d_req = 1'b0;
        check_eq("c_ddone", 32'(bus.d_done), 32'd1);
        check_eq("c_drd",   bus.d_rdata, 32'h1234_5678);
        check_eq("c_ifdn0", 32'(bus.if_done), 32'd0);
        tick();
        check_eq("c_gap2",  32'(bus.sram_en), 32'd0);
        tick();
        check_eq("c_fen",   32'(bus.sram_en), 32'd1);
        check_eq("c_faddr", bus.sram_addr, 32'h21);
        bus.sram_rdata = 32'hCAFE_F00D; bus.sram_read_done = 1'b1;
        tick();
        bus.sram_read_done = 1'b0; bus.if_req = 1'b0;
        check_eq("c_fdone", 32'(bus.if_done), 32'd1);
        check_eq("c_frd",   bus.if_rdata, 32'hCAFE_F00D);
        check_eq("c_drdh",  bus.d_rdata, 32'h1234_5678);
        repeat (2) tick();

        // Back-to-back fetches at PC 0 then PC 4
        bus.if_req = 1'b1; bus.if_addr = 32'h0;
        tick();
        check_eq("b_addr0", bus.sram_addr, 32'h1);
        bus.sram_rdata = 32'hAAAA_0001; bus.sram_read_done = 1'b1;
        tick();
        bus.sram_read_done = 1'b0; bus.if_addr = 32'h4;
        check_eq("b_rd0", bus.if_rdata, 32'hAAAA_0001);
        tick();
        check_eq("b_hold0", bus.if_rdata, 32'hAAAA_0001);
        tick();
        check_eq("b_addr1", bus.sram_addr, 32'h9);
        check_eq("b_hold1", bus.if_rdata, 32'hAAAA_0001);
        bus.sram_rdata = 32'hBBBB_0002; bus.sram_read_done = 1'b1;
        tick();
        bus.sram_read_done = 1'b0; bus.if_req = 1'b0;
        check_eq("b_rd1", bus.if_rdata, 32'hBBBB_0002);
        repeat (2) tick();

        // Reset in the middle of a data load
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h5;
        tick();
        check_eq("r_en", 32'(bus.sram_en), 32'd1);
        rst = 1'b0;
        #1;
        check_idle_outputs("r_async");
        bus.d_req = 1'b0;
        tick();
        rst = 1'b1;
        bus.sram_rdata = 32'h7777_7777; bus.sram_read_done = 1'b1;
        tick();
        bus.sram_read_done = 1'b0;
        check_eq("r_nodone", 32'(bus.d_done), 32'd0);
        check_eq("r_drd",    bus.d_rdata, 32'd0);
        tick();
        check_eq("r_nodone2", 32'(bus.d_done), 32'd0);
        check_eq("r_en0",     32'(bus.sram_en), 32'd0);

        // Unanswered fetch
        bus.if_req = 1'b1; bus.if_addr = 32'h10;
        tick();
`ifdef ARB_TIMEOUT_EN
        seen = 0;
        repeat (7) begin
            tick();
            if (bus.if_done) seen++;
        end
        check_eq("t_early", 32'(seen), 32'd0);
        tick();
        bus.if_req = 1'b0;
        check_eq("t_done",  32'(bus.if_done), 32'd1);
        check_eq("t_rdata", bus.if_rdata, 32'hDEAD_BEEF);
        check_eq("t_err",   32'(bus.arb_err), 32'd1);
        check_eq("t_en0",   32'(bus.sram_en), 32'd0);
        repeat (3) tick();
        check_eq("t_sticky", 32'(bus.arb_err), 32'd1);
`else
        seen = 0;
        repeat (40) begin
            tick();
            if (bus.if_done) seen++;
        end
        check_eq("w_nodone", 32'(seen), 32'd0);
        check_eq("w_en",     32'(bus.sram_en), 32'd1);
        check_eq("w_err",    32'(bus.arb_err), 32'd0);
        bus.if_req = 1'b0;
`endif
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_eq("end_err", 32'(bus.arb_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
